mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 132 +++++++++++++
 tb/tb_mem_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives a handshaked data memory, stalls upstream while an
// access is outstanding, and produces the MEM/WB register plus forwarding taps.
module mem_stage (
  input  logic         clk,
  input  logic         reset_b,
  input  logic [138:0] EX_MEM,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [31:0]  dmem_addr,
  output logic [31:0]  dmem_wdata,
  input  logic         dmem_ack,
  input  logic [31:0]  dmem_rdata,
  output logic         mem_stall,
  output logic [37:0]  MEM_WB,
  output logic [4:0]   EX_MEM_Rd,
  output logic         EX_MEM_RegWrite,
  output logic [31:0]  EX_MEM_RdData,
  output logic [4:0]   MEM_WB_Rd,
  output logic [31:0]  MEM_WB_RdData,
  output logic         MEM_WB_RegWrite
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]  state;
  logic [31:0] mem_write_data;
  logic [31:0] alu_result;
  logic [4:0]  write_reg;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic [1:0]  mem_to_reg;
  logic [31:0] pc_plus4;
  logic [31:0] lu_data;
  logic        lu_op;
  logic        mem_op;
  logic        is_load;
  logic [31:0] nonload_value;
  logic [31:0] wb_value;

  assign mem_write_data = EX_MEM[31:0];
  assign alu_result     = EX_MEM[63:32];
  assign write_reg      = EX_MEM[68:64];
  assign mem_read       = EX_MEM[69];
  assign mem_write      = EX_MEM[70];
  assign reg_write      = EX_MEM[71];
  assign mem_to_reg     = EX_MEM[73:72];
  assign pc_plus4       = EX_MEM[105:74];
  assign lu_data        = EX_MEM[137:106];
  assign lu_op          = EX_MEM[138];

  // A read+write combination is treated as a store, so it never captures load data.
  assign mem_op  = mem_read | mem_write;
  assign is_load = mem_read & ~mem_write;

  always_comb begin
    nonload_value = lu_op ? lu_data : alu_result;
    if (mem_to_reg == 2'b10) begin
      nonload_value = pc_plus4;
    end
  end

  always_comb begin
    wb_value = nonload_value;
    if (mem_to_reg == 2'b01 && is_load && state == BUSY) begin
      wb_value = dmem_rdata;
    end
  end

  always_comb begin
    mem_stall = 1'b0;
    if (state == IDLE) begin
      mem_stall = mem_op;
    end else begin
      mem_stall = ~dmem_ack;
    end
  end

  // Request side: an ack seen in IDLE falls through untouched, and returning to
  // IDLE after every ack guarantees a gap cycle between consecutive requests.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0;
      dmem_wdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            state      <= BUSY;
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write;
            dmem_addr  <= {alu_result[31:2], 2'b00};
            dmem_wdata <= mem_write_data;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            state    <= IDLE;
            dmem_req <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

  // Stalled edges inject a bubble by clearing RegWrite while the payload holds.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      MEM_WB <= 38'h0;
    end else if (mem_stall) begin
      MEM_WB[37] <= 1'b0;
    end else begin
      MEM_WB <= {reg_write, write_reg, wb_value};
    end
  end

  assign EX_MEM_Rd       = write_reg;
  assign EX_MEM_RegWrite = reg_write;
  assign EX_MEM_RdData   = nonload_value;
  assign MEM_WB_Rd       = MEM_WB[36:32];
  assign MEM_WB_RdData   = MEM_WB[31:0];
  assign MEM_WB_RegWrite = MEM_WB[37];

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: the driver queues expected MEM_WB writebacks,
// a monitor pops one whenever MEM_WB presents RegWrite=1.
module tb_mem_stage;

  logic         clk;
  logic         reset_b;
  logic [138:0] ex_mem;
  logic         dmem_req;
  logic         dmem_we;
  logic [31:0]  dmem_addr;
  logic [31:0]  dmem_wdata;
  logic         dmem_ack;
  logic [31:0]  dmem_rdata;
  logic         mem_stall;
  logic [37:0]  mem_wb;
  logic [4:0]   ex_mem_rd;
  logic         ex_mem_regwrite;
  logic [31:0]  ex_mem_rddata;
  logic [4:0]   mem_wb_rd;
  logic [31:0]  mem_wb_rddata;
  logic         mem_wb_regwrite;

  int checks = 0;
  int errors = 0;
  logic [37:0] exp_q[$];

  mem_stage dut (
    .clk(clk),
    .reset_b(reset_b),
    .EX_MEM(ex_mem),
    .dmem_req(dmem_req),
    .dmem_we(dmem_we),
    .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall),
    .MEM_WB(mem_wb),
    .EX_MEM_Rd(ex_mem_rd),
    .EX_MEM_RegWrite(ex_mem_regwrite),
    .EX_MEM_RdData(ex_mem_rddata),
    .MEM_WB_Rd(mem_wb_rd),
    .MEM_WB_RdData(mem_wb_rddata),
    .MEM_WB_RegWrite(mem_wb_regwrite)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [138:0] mk(input logic [31:0] wdata, input logic [31:0] alu,
                                      input logic [4:0] wr, input logic mr, input logic mw,
                                      input logic rw, input logic [1:0] m2r,
                                      input logic [31:0] pc4, input logic [31:0] lud,
                                      input logic luop);
    return {luop, lud, pc4, m2r, rw, mw, mr, wr, alu, wdata};
  endfunction

  task automatic check(input string name, input logic [37:0] actual, input logic [37:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Monitor: each cycle where MEM_WB carries a live writeback must match the queue head.
  always @(negedge clk) begin
    if (reset_b && mem_wb[37] === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_wb actual=%h expected=none", mem_wb);
      end else begin
        check("mem_wb", mem_wb, exp_q.pop_front());
      end
    end
  end

  task automatic run_op(input logic [138:0] ex, input int waits, input logic [31:0] rdata,
                        input logic [31:0] exp_addr, input logic [37:0] exp);
    logic        is_mem;
    logic [36:0] held;
    ex_mem   = ex;
    dmem_ack = 1'b0;
    if (exp[37]) exp_q.push_back(exp);
    is_mem = ex[69] | ex[70];
    #1;
    if (!is_mem) begin
      check("stall_nonmem", {37'h0, mem_stall}, 38'h0);
      @(posedge clk); #1;
    end else begin
      held = mem_wb[36:0];
      check("stall_idle", {37'h0, mem_stall}, 38'h1);
      check("req_idle", {37'h0, dmem_req}, 38'h0);
      @(posedge clk); #1;
      for (int w = 0; w <= waits; w++) begin
        check("req_busy", {37'h0, dmem_req}, 38'h1);
        check("addr", {6'h0, dmem_addr}, {6'h0, exp_addr});
        check("we", {37'h0, dmem_we}, {37'h0, ex[70]});
        check("wdata", {6'h0, dmem_wdata}, {6'h0, ex[31:0]});
        check("wb_bubble", {37'h0, mem_wb[37]}, 38'h0);
        check("wb_hold", {1'b0, mem_wb[36:0]}, {1'b0, held});
        if (w == waits) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rdata;
          #1;
          check("stall_ack", {37'h0, mem_stall}, 38'h0);
        end else begin
          check("stall_wait", {37'h0, mem_stall}, 38'h1);
        end
        @(posedge clk); #1;
      end
      dmem_ack = 1'b0;
      check("req_after_ack", {37'h0, dmem_req}, 38'h0);
    end
  endtask

  task automatic applyStimulus();
    ex_mem     = '0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    reset_b    = 1'b0;
    #1;
    check("rst_req", {37'h0, dmem_req}, 38'h0);
    check("rst_addr", {6'h0, dmem_addr}, 38'h0);
    check("rst_memwb", mem_wb, 38'h0);
    check("rst_stall", {37'h0, mem_stall}, 38'h0);
    @(negedge clk);
    @(negedge clk);
    reset_b = 1'b1;

    // ALU op then load, separated by a bubble
    run_op(mk(0, 32'h1234, 5'd8, 0, 0, 1, 2'b00, 0, 0, 0), 0, 0, 0, {1'b1, 5'd8, 32'h1234});
    run_op('0, 0, 0, 0, 38'h0);
    run_op(mk(0, 32'h100, 5'd9, 1, 0, 1, 2'b01, 0, 0, 0), 0, 32'hDEADBEEF, 32'h100,
           {1'b1, 5'd9, 32'hDEADBEEF});

    // ALU op immediately followed by a 3-wait store that still writes back
    run_op(mk(0, 32'h55, 5'd3, 0, 0, 1, 2'b00, 0, 0, 0), 0, 0, 0, {1'b1, 5'd3, 32'h55});
    run_op(mk(32'hA5A5A5A5, 32'h207, 5'd5, 0, 1, 1, 2'b00, 0, 0, 0), 3, 0, 32'h204,
           {1'b1, 5'd5, 32'h207});
    run_op('0, 0, 0, 0, 38'h0);

    // jal and lui writeback select, lui also checked on the forwarding tap
    run_op(mk(0, 32'h999, 5'd31, 0, 0, 1, 2'b10, 32'h40, 0, 0), 0, 0, 0, {1'b1, 5'd31, 32'h40});
    ex_mem = mk(0, 32'h1, 5'd4, 0, 0, 1, 2'b00, 0, 32'hABCD0000, 1);
    #1;
    check("fwd_lui", {6'h0, ex_mem_rddata}, {6'h0, 32'hABCD0000});
    check("fwd_rd", {33'h0, ex_mem_rd}, 38'd4);
    run_op(mk(0, 32'h1, 5'd4, 0, 0, 1, 2'b00, 0, 32'hABCD0000, 1), 0, 0, 0,
           {1'b1, 5'd4, 32'hABCD0000});

    // Read+write together behaves as a store: no load data captured
    run_op(mk(32'h9, 32'h30, 5'd6, 1, 1, 1, 2'b01, 0, 0, 0), 0, 32'h12345678, 32'h30,
           {1'b1, 5'd6, 32'h30});

    // Back-to-back loads, each passes through IDLE
    run_op(mk(0, 32'h10, 5'd10, 1, 0, 1, 2'b01, 0, 0, 0), 0, 32'h11111111, 32'h10,
           {1'b1, 5'd10, 32'h11111111});
    run_op(mk(0, 32'h14, 5'd11, 1, 0, 1, 2'b01, 0, 0, 0), 0, 32'h22222222, 32'h14,
           {1'b1, 5'd11, 32'h22222222});
    run_op('0, 0, 0, 0, 38'h0);

    // Stray ack in IDLE must not start anything
    dmem_ack = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check("idle_ack_req", {37'h0, dmem_req}, 38'h0);

    // Reset during the second wait cycle of a store
    ex_mem = mk(32'h77, 32'h300, 5'd0, 0, 1, 0, 2'b00, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_req", {37'h0, dmem_req}, 38'h1);
    reset_b = 1'b0;
    #1;
    check("midrst_req", {37'h0, dmem_req}, 38'h0);
    check("midrst_memwb", mem_wb, 38'h0);
    ex_mem = '0;
    @(negedge clk);
    reset_b = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b1;
    #1;
    check("stray_stall", {37'h0, mem_stall}, 38'h0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check("stray_req", {37'h0, dmem_req}, 38'h0);
    check("stray_memwb", mem_wb, 38'h0);
    @(posedge clk); #1;
    check("stray_idle_req", {37'h0, dmem_req}, 38'h0);
  endtask

  task automatic checkOutput();
    repeat (2) @(posedge clk);
    check("queue_drained", 38'(exp_q.size()), 38'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
  endtask

  initial begin
    applyStimulus();
    checkOutput();
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
